e203_subsys_rst_seq: RTL and testbench



---
 rtl/e203_rst_seq_pkg.sv | 20 ++
 rtl/e203_rst_seq_dly_cnt.sv | 33 +++
 rtl/e203_subsys_rst_seq.sv | 120 ++++++++++++
 tb/tb_e203_subsys_rst_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_rst_seq_pkg.sv
// Shared types and defaults for the subsystem reset sequencer.
//   rst_state_e : sequencer FSM states (3-bit encoding)
//   DEF_*       : default timing parameters
package e203_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD        = 3'd0,
    ST_REL_BUS     = 3'd1,
    ST_REL_CORE    = 3'd2,
    ST_RUN         = 3'd3,
    ST_SOFT_PERIPH = 3'd4,
    ST_SOFT_CORE   = 3'd5,
    ST_SOFT_HOLD   = 3'd6
  } rst_state_e;

  localparam int DEF_STAGE_DLY = 16;
  localparam int DEF_SOFT_HOLD = 8;
  localparam int DEF_DLY_W     = 8;

endpackage

// File: rtl/e203_rst_seq_dly_cnt.sv
// Delay counter for the reset sequencer.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (wins over en)
//   en         : count up by one
//   tc         : terminal count (limit-1)
//   done       : high while enabled and count == tc
module e203_rst_seq_dly_cnt #(
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DLY_W-1:0] tc,
  output logic             done
);

  logic [DLY_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + DLY_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = en && (cnt_q == tc);

endmodule

// File: rtl/e203_subsys_rst_seq.sv
// Subsystem reset sequencer. Releases bus, core, peripheral resets in order
// with STAGE_DLY spacing; a soft-reset request re-asserts them in reverse
// order, holds for SOFT_HOLD cycles, then re-runs the release.
//   clk           : HCLK
//   rst_n_a       : synchronized global reset, async assert, active-low
//   test_mode     : DFT bypass, reset outputs follow rst_n_a directly
//   soft_rst_req  : one-cycle request, only honoured in RUN
//   soft_rst_ack  : one-cycle pulse when a soft reset completes
//   seq_busy      : FSM not in RUN
//   bus_rst_n, core_rst_n, periph_rst_n : staged active-low resets
module e203_subsys_rst_seq
  import e203_rst_seq_pkg::*;
#(
  parameter int STAGE_DLY = DEF_STAGE_DLY,
  parameter int SOFT_HOLD = DEF_SOFT_HOLD,
  parameter int DLY_W     = DEF_DLY_W
) (
  input  logic clk,
  input  logic rst_n_a,
  input  logic test_mode,
  input  logic soft_rst_req,
  output logic soft_rst_ack,
  output logic seq_busy,
  output logic bus_rst_n,
  output logic core_rst_n,
  output logic periph_rst_n
);

  localparam logic [DLY_W-1:0] STAGE_TC = DLY_W'(STAGE_DLY - 1);
  localparam logic [DLY_W-1:0] HOLD_TC  = DLY_W'(SOFT_HOLD - 1);

  rst_state_e       state_q, state_d;
  logic             soft_q, soft_d;
  logic             bus_q, bus_d, core_q, core_d, periph_q, periph_d;
  logic             ack_q, ack_d, busy_q, busy_d;
  logic             cnt_en, cnt_clr, cnt_done, enter_run;
  logic [DLY_W-1:0] cnt_tc;

  e203_rst_seq_dly_cnt #(.DLY_W(DLY_W)) u_dly_cnt (
    .clk   (clk),
    .rst_n (rst_n_a),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc),
    .done  (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    soft_d  = soft_q;
    cnt_en  = 1'b1;
    cnt_tc  = STAGE_TC;
    case (state_q)
      ST_HOLD:        if (cnt_done) state_d = ST_REL_BUS;
      ST_REL_BUS:     if (cnt_done) state_d = ST_REL_CORE;
      ST_REL_CORE:    if (cnt_done) state_d = ST_RUN;
      ST_RUN: begin
        cnt_en = 1'b0;
        if (soft_rst_req) begin
          state_d = ST_SOFT_PERIPH;
          soft_d  = 1'b1;
        end
      end
      ST_SOFT_PERIPH: if (cnt_done) state_d = ST_SOFT_CORE;
      ST_SOFT_CORE:   if (cnt_done) state_d = ST_SOFT_HOLD;
      ST_SOFT_HOLD: begin
        cnt_tc = HOLD_TC;
        if (cnt_done) state_d = ST_HOLD;
      end
      default: begin
        cnt_en  = 1'b0;
        state_d = ST_HOLD;
      end
    endcase

    // every state entry restarts the delay count
    cnt_clr   = (state_d != state_q);
    enter_run = (state_d == ST_RUN) && (state_q != ST_RUN);
    // ack only for a soft-initiated release; flag consumed on the same edge
    ack_d     = enter_run && soft_q;
    if (enter_run) soft_d = 1'b0;

    // outputs decoded from the next state so they switch with the state flop
    bus_d    = (state_d == ST_REL_BUS) || (state_d == ST_REL_CORE) ||
               (state_d == ST_RUN) || (state_d == ST_SOFT_PERIPH) ||
               (state_d == ST_SOFT_CORE);
    core_d   = (state_d == ST_REL_CORE) || (state_d == ST_RUN) ||
               (state_d == ST_SOFT_PERIPH);
    periph_d = (state_d == ST_RUN);
    busy_d   = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      state_q  <= ST_HOLD;
      soft_q   <= 1'b0;
      bus_q    <= 1'b0;
      core_q   <= 1'b0;
      periph_q <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      soft_q   <= soft_d;
      bus_q    <= bus_d;
      core_q   <= core_d;
      periph_q <= periph_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  // DFT bypass sits after the registers; FSM status outputs stay sequenced
  assign bus_rst_n    = test_mode ? rst_n_a : bus_q;
  assign core_rst_n   = test_mode ? rst_n_a : core_q;
  assign periph_rst_n = test_mode ? rst_n_a : periph_q;
  assign soft_rst_ack = ack_q;
  assign seq_busy     = busy_q;

endmodule

// File: tb/tb_e203_subsys_rst_seq.sv
`timescale 1ns/1ps
module tb_e203_subsys_rst_seq;

  logic clk = 1'b0;
  logic rst_n_a = 1'b1;
  logic test_mode = 1'b0;
  logic req [2];
  logic bus [2], core [2], periph [2], busy [2], ack [2];
  int   n_chk = 0, n_fail = 0;
  int   ack_cnt [2];
  int   a0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // inst 0: STAGE_DLY=4 SOFT_HOLD=2 ; inst 1: STAGE_DLY=1 SOFT_HOLD=1
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int S   = (g == 0) ? 4 : 1;
    localparam int H   = (g == 0) ? 2 : 1;
    localparam int OFF = 2 * S + H;  // soft request edge -> release restart

    // model: m_t = edges since power-on release (m_soft=0) or since the
    // sampled soft request (m_soft=1); outputs are a pure function of it
    int m_t = 0;
    bit m_soft = 1'b0;

    e203_subsys_rst_seq #(.STAGE_DLY(S), .SOFT_HOLD(H), .DLY_W(8)) dut (
      .clk          (clk),
      .rst_n_a      (rst_n_a),
      .test_mode    (test_mode),
      .soft_rst_req (req[g]),
      .soft_rst_ack (ack[g]),
      .seq_busy     (busy[g]),
      .bus_rst_n    (bus[g]),
      .core_rst_n   (core[g]),
      .periph_rst_n (periph[g])
    );

    function automatic bit in_run(input bit s, input int t);
      return s ? (t >= OFF + 3 * S) : (t >= 3 * S);
    endfunction

    always @(posedge clk or negedge rst_n_a) begin
      if (!rst_n_a) begin
        m_soft <= 1'b0;
        m_t    <= 0;
      end else if (in_run(m_soft, m_t)) begin
        if (req[g]) begin
          m_soft <= 1'b1;
          m_t    <= 0;
        end else begin
          m_soft <= 1'b0;
          m_t    <= 3 * S;
        end
      end else begin
        m_t <= m_t + 1;
      end
    end

    always @(negedge clk) begin
      bit eb, ec, ep;
      int u;
      if (m_soft && m_t < OFF) begin
        eb = (m_t < 2 * S);
        ec = (m_t < S);
        ep = 1'b0;
      end else begin
        u  = m_soft ? m_t - OFF : m_t;
        eb = (u >= S);
        ec = (u >= 2 * S);
        ep = (u >= 3 * S);
      end
      if (test_mode) begin
        eb = rst_n_a;
        ec = rst_n_a;
        ep = rst_n_a;
      end
      chk($sformatf("m%0d_bus", g), bus[g], eb);
      chk($sformatf("m%0d_core", g), core[g], ec);
      chk($sformatf("m%0d_periph", g), periph[g], ep);
      chk($sformatf("m%0d_busy", g), busy[g], !in_run(m_soft, m_t));
      chk($sformatf("m%0d_ack", g), ack[g], m_soft && (m_t == OFF + 3 * S));
      if (ack[g] === 1'b1) ack_cnt[g]++;
    end
  end

  initial begin
    req[0] = 1'b0;
    req[1] = 1'b0;
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    #1 rst_n_a = 1'b0;
    step(3);
    chk("rst_bus", bus[0], 1'b0);
    chk("rst_core", core[0], 1'b0);
    chk("rst_periph", periph[0], 1'b0);
    chk("rst_busy", busy[0], 1'b1);
    chk("rst_ack", ack[0], 1'b0);

    // power-on release; next posedge is edge 1
    rst_n_a = 1'b1;
    step(1);
    chk("d1_bus_e1", bus[1], 1'b1);
    chk("d1_core_e1", core[1], 1'b0);
    step(1);
    chk("d1_core_e2", core[1], 1'b1);
    chk("d1_periph_e2", periph[1], 1'b0);
    step(1);
    chk("d1_periph_e3", periph[1], 1'b1);
    chk("d1_busy_e3", busy[1], 1'b0);
    chk("d0_bus_e3", bus[0], 1'b0);
    step(1);
    chk("d0_bus_e4", bus[0], 1'b1);
    chk("d0_core_e4", core[0], 1'b0);
    step(4);
    chk("d0_core_e8", core[0], 1'b1);
    step(3);
    chk("d0_periph_e11", periph[0], 1'b0);
    chk("d0_busy_e11", busy[0], 1'b1);
    step(1);
    chk("d0_periph_e12", periph[0], 1'b1);
    chk("d0_busy_e12", busy[0], 1'b0);
    chk("d0_ack_e12", ack[0], 1'b0);
    step(4);
    chk("pwr_no_ack", ack_cnt[0] == 0 && ack_cnt[1] == 0, 1'b1);

    // soft reset on inst 0 with extra requests while busy
    a0 = ack_cnt[0];
    req[0] = 1'b1;
    step(1);
    req[0] = 1'b0;
    chk("s_periph_0", periph[0], 1'b0);
    chk("s_core_0", core[0], 1'b1);
    chk("s_busy_0", busy[0], 1'b1);
    for (int i = 1; i <= 30; i++) begin
      req[0] = (i == 1 || i == 15);
      step(1);
      req[0] = 1'b0;
      if (i == 4)  chk("s_core_4", core[0], 1'b0);
      if (i == 7)  chk("s_bus_7", bus[0], 1'b1);
      if (i == 8)  chk("s_bus_8", bus[0], 1'b0);
      if (i == 13) chk("s_bus_13", bus[0], 1'b0);
      if (i == 14) chk("s_bus_14", bus[0], 1'b1);
      if (i == 18) chk("s_core_18", core[0], 1'b1);
      if (i == 21) chk("s_periph_21", periph[0], 1'b0);
      if (i == 22) begin
        chk("s_periph_22", periph[0], 1'b1);
        chk("s_ack_22", ack[0], 1'b1);
        chk("s_busy_22", busy[0], 1'b0);
      end
      if (i == 23) chk("s_ack_23", ack[0], 1'b0);
    end
    chk("s_one_ack", (ack_cnt[0] - a0) == 1, 1'b1);
    chk("s_run_held", busy[0], 1'b0);

    // inst 1: request held across the RUN entry edge is taken one cycle later
    req[1] = 1'b1;
    step(1);
    req[1] = 1'b0;
    chk("b_busy_0", busy[1], 1'b1);
    step(5);
    req[1] = 1'b1;
    step(1);
    chk("b_ack_6", ack[1], 1'b1);
    chk("b_periph_6", periph[1], 1'b1);
    step(1);
    req[1] = 1'b0;
    chk("b_periph_7", periph[1], 1'b0);
    chk("b_busy_7", busy[1], 1'b1);
    chk("b_ack_7", ack[1], 1'b0);
    step(10);

    // global reset during SOFT_CORE
    a0 = ack_cnt[0];
    req[0] = 1'b1;
    step(1);
    req[0] = 1'b0;
    step(5);
    chk("r_bus_pre", bus[0], 1'b1);
    #1 rst_n_a = 1'b0;
    #1;
    chk("r_bus_async", bus[0], 1'b0);
    chk("r_core_async", core[0], 1'b0);
    chk("r_periph_async", periph[0], 1'b0);
    chk("r_busy_async", busy[0], 1'b1);
    step(2);
    rst_n_a = 1'b1;
    step(11);
    chk("r_periph_e11", periph[0], 1'b0);
    step(1);
    chk("r_periph_e12", periph[0], 1'b1);
    step(10);
    chk("r_no_ack", ack_cnt[0] == a0, 1'b1);

    // request and reset in the same cycle
    req[0] = 1'b1;
    rst_n_a = 1'b0;
    step(1);
    req[0] = 1'b0;
    rst_n_a = 1'b1;
    step(14);
    chk("rq_no_ack", ack_cnt[0] == a0, 1'b1);
    chk("rq_busy", busy[0], 1'b0);

    // DFT bypass
    test_mode = 1'b1;
    #1 rst_n_a = 1'b0;
    #1;
    chk("t_bus_lo", bus[0], 1'b0);
    chk("t_periph_lo", periph[0], 1'b0);
    step(1);
    rst_n_a = 1'b1;
    #1;
    chk("t_bus_hi", bus[0], 1'b1);
    chk("t_core_hi", core[0], 1'b1);
    step(5);
    chk("t_periph_relbus", periph[0], 1'b1);
    chk("t_busy_relbus", busy[0], 1'b1);
    #1 rst_n_a = 1'b0;
    #1;
    chk("t_core_lo", core[0], 1'b0);
    rst_n_a = 1'b1;
    test_mode = 1'b0;
    step(20);

    // randomized traffic, checked by the per-cycle model compare
    for (int i = 0; i < 1500; i++) begin
      req[0]    = ($urandom_range(0, 7) == 0);
      req[1]    = ($urandom_range(0, 5) == 0);
      rst_n_a   = ($urandom_range(0, 299) != 0);
      test_mode = ($urandom_range(0, 99) < 3);
      step(1);
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    rst_n_a = 1'b1;
    test_mode = 1'b0;
    step(40);
    chk("end_run0", busy[0], 1'b0);
    chk("end_run1", busy[1], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
